// File: rtl/fft_reorder_if.sv
// Sample stream bundle for the FFT reorder buffer: bit-reversed input side and natural-order output side.
interface fft_reorder_if #(
    parameter int WIDTH = 8
);
    logic                    mode_bitrev;
    logic                    enable_in;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic                    enable_out;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic                    frame_start;

    modport master (
        output mode_bitrev, enable_in, in_re, in_im,
        input  enable_out, out_re, out_im, frame_start
    );

    modport slave (
        input  mode_bitrev, enable_in, in_re, in_im,
        output enable_out, out_re, out_im, frame_start
    );
endinterface

// File: rtl/fft_reorder.sv
// Ping-pong buffer turning bit-reversed FFT frames into natural order; sample 0 out 2 cycles after a frame's last accept.
// No backpressure: input may gap freely, each full bank is drained gap-free in exactly N cycles.
module fft_reorder #(
    parameter int N     = 1024,
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    fft_reorder_if.slave bus
);
    localparam int AW = $clog2(N);

    typedef enum logic {IDLE, READ} state_t;

    state_t              state;
    logic [AW-1:0]       wr_cnt;
    logic [AW-1:0]       rd_cnt;
    logic [AW-1:0]       wr_addr;
    logic                wr_bank;
    logic                rd_bank;
    logic                mode_q;
    logic                wr_mode;
    logic                wr_last;
    logic                rd_done;
    logic                other_rdy;
    logic [1:0]          full;
    logic [1:0]          full_set;
    logic [1:0]          full_clr;
    logic [2*WIDTH-1:0]  mem [2*N];
    logic [2*WIDTH-1:0]  rd_dat;
    logic                rd_vld;
    logic                rd_first;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    // The first sample of a frame uses the live mode pin; later samples use the latched copy.
    assign wr_mode = (wr_cnt == '0) ? bus.mode_bitrev : mode_q;
    assign wr_addr = wr_mode ? bitrev(wr_cnt) : wr_cnt;
    assign wr_last = bus.enable_in && (wr_cnt == AW'(N - 1));

    always_comb begin
        full_set  = 2'b00;
        full_clr  = 2'b00;
        rd_done   = (state == READ) && (rd_cnt == AW'(N - 1));
        if (wr_last) full_set = 2'b01 << wr_bank;
        if (rd_done) full_clr = 2'b01 << rd_bank;
        other_rdy = full[~rd_bank] | full_set[~rd_bank];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            mode_q  <= 1'b0;
        end else if (bus.enable_in) begin
            wr_cnt <= wr_cnt + AW'(1);
            if (wr_cnt == '0) mode_q <= bus.mode_bitrev;
            if (wr_last) wr_bank <= ~wr_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.enable_in && !rst) begin
            mem[{wr_bank, wr_addr}] <= {bus.in_re, bus.in_im};
        end
        rd_dat <= mem[{rd_bank, rd_cnt}];
    end

    // Reader enters READ on the completing edge itself so address 0 is issued in the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            rd_bank  <= 1'b0;
            full     <= 2'b00;
            rd_vld   <= 1'b0;
            rd_first <= 1'b0;
        end else begin
            full     <= (full | full_set) & ~full_clr;
            rd_vld   <= (state == READ);
            rd_first <= (state == READ) && (rd_cnt == '0);
            case (state)
                IDLE: begin
                    if (wr_last) begin
                        state   <= READ;
                        rd_bank <= wr_bank;
                        rd_cnt  <= '0;
                    end
                end
                READ: begin
                    rd_cnt <= rd_cnt + AW'(1);
                    if (rd_done) begin
                        if (other_rdy) rd_bank <= ~rd_bank;
                        else           state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.enable_out  <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.out_re      <= '0;
            bus.out_im      <= '0;
        end else begin
            bus.enable_out  <= rd_vld;
            bus.frame_start <= rd_first;
            if (rd_vld) begin
                bus.out_re <= rd_dat[2*WIDTH-1:WIDTH];
                bus.out_im <= rd_dat[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder at N=16: ordering, latency, back-to-back, gaps, mode latch, reset.
module tb_fft_reorder;
    localparam int N = 16;
    localparam int W = 8;
    localparam int BR [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    typedef struct {
        int                  c;
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        logic                fs;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    smp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_reorder_if #(.WIDTH(W)) bus ();

    fft_reorder #(.N(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.enable_out === 1'b1) q.push_back('{cyc, bus.out_re, bus.out_im, bus.frame_start});
    end

    task automatic chk(input int obs, input int exp, input string tag);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one frame; mode switches to ~m from sample flip_at on; gap inserts an idle cycle after each sample.
    task automatic send(input int first, input bit m, input bit gap, input int flip_at, output int t);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            bus.enable_in   = 1'b1;
            bus.in_re       = W'(first + k);
            bus.in_im       = W'(-(first + k));
            bus.mode_bitrev = (k < flip_at) ? m : ~m;
            t = cyc + 1;
            if (gap) begin
                @(negedge clk);
                bus.enable_in = 1'b0;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.enable_in = 1'b0;
    endtask

    task automatic check_frame(input int t, input int first, input bit br, input string tag);
        int   budget;
        smp_t s;
        budget = 4 * N;
        while (q.size() < N && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk((q.size() >= N) ? 1 : 0, 1, {tag, " count"});
        for (int k = 0; k < N && q.size() > 0; k++) begin
            int src;
            src = br ? BR[k] : k;
            s = q.pop_front();
            chk(s.c, t + 2 + k, $sformatf("%s cycle[%0d]", tag, k));
            chk(int'(s.re), first + src, $sformatf("%s re[%0d]", tag, k));
            chk(int'(s.im), -(first + src), $sformatf("%s im[%0d]", tag, k));
            chk(int'(s.fs), (k == 0) ? 1 : 0, $sformatf("%s frame_start[%0d]", tag, k));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, ta, tb, tc;
        smp_t s;
        bus.enable_in   = 1'b0;
        bus.mode_bitrev = 1'b0;
        bus.in_re       = '0;
        bus.in_im       = '0;
        repeat (3) @(negedge clk);
        chk(int'(bus.enable_out), 0, "reset enable_out");
        chk(int'(bus.frame_start), 0, "reset frame_start");
        chk(int'(bus.out_re), 0, "reset out_re");
        chk(int'(bus.out_im), 0, "reset out_im");
        rst = 1'b0;

        send(0, 1'b1, 1'b0, N, t0);
        idle();
        check_frame(t0, 0, 1'b1, "bitrev");

        send(0, 1'b0, 1'b0, N, t0);
        idle();
        check_frame(t0, 0, 1'b0, "natural");

        send(0, 1'b1, 1'b0, N, t0);
        send(16, 1'b1, 1'b0, N, t1);
        send(32, 1'b1, 1'b0, N, t2);
        idle();
        check_frame(t0, 0, 1'b1, "b2b f0");
        check_frame(t0 + 16, 16, 1'b1, "b2b f1");
        check_frame(t0 + 32, 32, 1'b1, "b2b f2");

        send(50, 1'b1, 1'b1, N, t0);
        check_frame(t0, 50, 1'b1, "gapped");

        send(0, 1'b1, 1'b0, 5, t0);
        send(16, 1'b0, 1'b0, N, t1);
        idle();
        check_frame(t0, 0, 1'b1, "flip f0");
        check_frame(t1, 16, 1'b0, "flip f1");

        send(0, 1'b1, 1'b0, N, ta);
        send(16, 1'b1, 1'b0, N, tb);
        idle();
        while (cyc < tb + 9) @(negedge clk);
        rst             = 1'b1;
        bus.enable_in   = 1'b1;
        bus.in_re       = W'(99);
        bus.in_im       = W'(99);
        bus.mode_bitrev = 1'b0;
        @(negedge clk);
        rst           = 1'b0;
        bus.enable_in = 1'b0;
        chk(int'(bus.enable_out), 0, "post-reset enable_out");
        chk(int'(bus.frame_start), 0, "post-reset frame_start");
        chk(int'(bus.out_re), 0, "post-reset out_re");
        repeat (20) @(negedge clk);
        chk(q.size(), N + 8, "pre-reset sample count");
        check_frame(ta, 0, 1'b1, "rst fA");
        for (int k = 0; k < 8 && q.size() > 0; k++) begin
            s = q.pop_front();
            chk(s.c, tb + 2 + k, $sformatf("rst fB cycle[%0d]", k));
            chk(int'(s.re), 16 + BR[k], $sformatf("rst fB re[%0d]", k));
        end
        chk(q.size(), 0, "no residual after reset");

        send(40, 1'b1, 1'b0, N, tc);
        idle();
        check_frame(tc, 40, 1'b1, "fresh");
        repeat (N + 4) @(negedge clk);
        chk(q.size(), 0, "no trailing samples");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
